// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types, defaults and helpers for the centre-aligned PWM block
package pwm_pkg;
  localparam int CNT_W_DEF = 11;
  localparam int DT_W_DEF  = 6;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic [1:0] {IDLE_LOW, WAIT_DT, DRIVE} dt_st_e;
  // bit offset of channel ch inside a packed per-channel compare bus of w-bit fields
  function automatic int unsigned cmp_lsb(int unsigned ch, int unsigned w);
    return ch * w;
  endfunction
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary high/low drive with dead time inserted on every raw edge
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            raw,
  input  logic [DT_W-1:0] dt,
  input  logic            en,
  output logic            h,
  output logic            l
);
  localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);
  dt_st_e hs_q, hs_d, ls_q, ls_d, act;
  logic [DT_W-1:0] dtc_q, dtc_d;

  // a side drops as soon as its target goes low and rises only after a full dead time of stable target
  function automatic dt_st_e side_nxt(dt_st_e st, logic tgt, logic [DT_W-1:0] c, logic [DT_W-1:0] d);
    return !tgt ? IDLE_LOW :
           st == IDLE_LOW ? (d == '0 ? DRIVE : WAIT_DT) :
           st == WAIT_DT ? (c <= DT_ONE ? DRIVE : WAIT_DT) : DRIVE;
  endfunction

  // side states and the shared dead-time counter
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      hs_q  <= IDLE_LOW;
      ls_q  <= IDLE_LOW;
      dtc_q <= '0;
    end else begin
      hs_q  <= hs_d;
      ls_q  <= ls_d;
      dtc_q <= dtc_d;
    end

  // next state; only the side whose target is high can be waiting, so one counter serves both
  always_comb begin
    act   = raw ? hs_q : ls_q;
    hs_d  = en ? side_nxt(hs_q, raw, dtc_q, dt) : IDLE_LOW;
    ls_d  = en ? side_nxt(ls_q, ~raw, dtc_q, dt) : IDLE_LOW;
    dtc_d = !en ? '0 : act == IDLE_LOW ? dt : act == WAIT_DT ? dtc_q - DT_ONE : dtc_q;
  end

  // outputs decode registered state only, so both sides can never be driven together
  always_comb begin
    h = hs_q == DRIVE;
    l = ls_q == DRIVE;
  end
endmodule

// File: rtl/pwm_center_dt_multi.sv
// pwm_center_dt_multi: triangle-carrier multi-channel PWM with shadowed settings and dead time
module pwm_center_dt_multi
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int CH_N    = 3,
  parameter int DT_W    = DT_W_DEF,
  parameter int PER_DEF = 1563,
  parameter int CMP_DEF = 780,
  parameter int DT_DEF  = 40
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [CNT_W-1:0]      period,
  input  logic [CH_N*CNT_W-1:0] cmp,
  input  logic [DT_W-1:0]       deadtime,
  output logic                  load_ack,
  output logic [CH_N-1:0]       pwm_h,
  output logic [CH_N-1:0]       pwm_l,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  dir_o,
  output logic                  zero_evt,
  output logic                  peak_evt
);
  localparam logic [CNT_W-1:0]      ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]      PER_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0]      PER_RST = CNT_W'(PER_DEF);
  localparam logic [CH_N*CNT_W-1:0] CMP_RST = {CH_N{CNT_W'(CMP_DEF)}};
  localparam logic [DT_W-1:0]       DT_RST  = DT_W'(DT_DEF);

  logic [CNT_W-1:0]      cnt_q, cnt_d, per_q, per_d, per_sh_q, per_sh_d, per_eff;
  logic [CH_N*CNT_W-1:0] cmp_q, cmp_d, cmp_sh_q, cmp_sh_d;
  logic [DT_W-1:0]       dt_q, dt_d, dt_sh_q, dt_sh_d;
  logic                  pend_q, pend_d, xfer;
  logic [CH_N-1:0]       raw;
  dir_e                  dir_q, dir_d;

  // carrier, active and shadow registers
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      per_q    <= PER_RST;
      cmp_q    <= CMP_RST;
      dt_q     <= DT_RST;
      per_sh_q <= PER_RST;
      cmp_sh_q <= CMP_RST;
      dt_sh_q  <= DT_RST;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      per_q    <= per_d;
      cmp_q    <= cmp_d;
      dt_q     <= dt_d;
      per_sh_q <= per_sh_d;
      cmp_sh_q <= cmp_sh_d;
      dt_sh_q  <= dt_sh_d;
      pend_q   <= pend_d;
    end

  // triangle carrier 0..per..0; direction turns one step early so the count lands on the peak and valley
  always_comb begin
    per_eff = per_q < PER_MIN ? PER_MIN : per_q;
    cnt_d   = !en ? '0 : dir_q == DIR_UP ? cnt_q + ONE : cnt_q - ONE;
    dir_d   = !en ? DIR_UP :
              (dir_q == DIR_UP && cnt_q == per_eff - ONE) ? DIR_DOWN :
              (dir_q == DIR_DOWN && cnt_q == ONE) ? DIR_UP : dir_q;
  end

  // shadow capture and valley transfer; a load in the transfer cycle re-arms for the next valley
  always_comb begin
    xfer     = pend_q && cnt_q == '0;
    pend_d   = load || (pend_q && !xfer);
    per_sh_d = load ? period : per_sh_q;
    cmp_sh_d = load ? cmp : cmp_sh_q;
    dt_sh_d  = load ? deadtime : dt_sh_q;
    per_d    = xfer ? per_sh_q : per_q;
    cmp_d    = xfer ? cmp_sh_q : cmp_q;
    dt_d     = xfer ? dt_sh_q : dt_q;
  end

  for (genvar i = 0; i < CH_N; i++) begin : g_ch
    assign raw[i] = cnt_q >= cmp_q[cmp_lsb(i, CNT_W) +: CNT_W];
    pwm_deadtime #(.DT_W(DT_W)) u_dt (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .raw      (raw[i]),
      .dt       (dt_q),
      .en       (en),
      .h        (pwm_h[i]),
      .l        (pwm_l[i])
    );
  end

  assign load_ack = xfer;
  assign cnt_o    = cnt_q;
  assign dir_o    = dir_q;
  assign zero_evt = en && cnt_q == '0;
  assign peak_evt = en && cnt_q == per_eff;
endmodule

// File: tb/tb_pwm_center_dt_multi.sv
// tb_pwm_center_dt_multi: scoreboard-driven directed test of the centre-aligned PWM
module tb_pwm_center_dt_multi;
  localparam int CW = 11;
  localparam int CH = 3;
  localparam int DW = 6;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [CW-1:0] period = '0;
  logic [CH*CW-1:0] cmp = '0;
  logic [DW-1:0] deadtime = '0;
  logic          load_ack, dir_o, zero_evt, peak_evt;
  logic [CH-1:0] pwm_h, pwm_l;
  logic [CW-1:0] cnt_o;
  int            total = 0;
  int            bad = 0;
  int            acks = 0;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          dir;
    logic [CH-1:0] h;
    logic [CH-1:0] l;
  } exp_t;
  exp_t sbq[$];

  // reference: carrier as a phase index, dead time as run lengths of stable raw samples
  int m_ph, m_pe, m_dt, sh_pe, sh_dt;
  int m_cmp[CH], sh_cmp[CH], run1[CH], run0[CH], ldt[CH];
  bit m_pend;

  always #5 sys_clk = ~sys_clk;

  pwm_center_dt_multi #(.CNT_W(CW), .CH_N(CH), .DT_W(DW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (en),
    .load     (load),
    .period   (period),
    .cmp      (cmp),
    .deadtime (deadtime),
    .load_ack (load_ack),
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l),
    .cnt_o    (cnt_o),
    .dir_o    (dir_o),
    .zero_evt (zero_evt),
    .peak_evt (peak_evt)
  );

  function automatic int pe_eff();
    return m_pe < 2 ? 2 : m_pe;
  endfunction

  function automatic int cur_cnt();
    return m_ph <= pe_eff() ? m_ph : 2 * pe_eff() - m_ph;
  endfunction

  function automatic bit cur_dir();
    return m_ph >= pe_eff();
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic m_reset();
    m_ph = 0;
    m_pe = 1563;
    sh_pe = 1563;
    m_dt = 40;
    sh_dt = 40;
    m_pend = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_cmp[i] = 780;
      sh_cmp[i] = 780;
      run1[i] = 0;
      run0[i] = 0;
      ldt[i] = 0;
    end
    sbq.delete();
    sbq.push_back('0);
  endtask

  task automatic step();
    exp_t e, n;
    int c;
    bit xfer;
    @(negedge sys_clk);
    c = cur_cnt();
    xfer = m_pend && c == 0;
    e = sbq.pop_front();
    chk("cnt", 32'(cnt_o), 32'(e.cnt));
    chk("dir", 32'(dir_o), 32'(e.dir));
    chk("pwm_h", 32'(pwm_h), 32'(e.h));
    chk("pwm_l", 32'(pwm_l), 32'(e.l));
    chk("overlap", 32'(pwm_h & pwm_l), 32'(0));
    chk("zero_evt", 32'(zero_evt), 32'(en && c == 0));
    chk("peak_evt", 32'(peak_evt), 32'(en && c == pe_eff()));
    chk("load_ack", 32'(load_ack), 32'(xfer));
    acks += int'(load_ack);
    n = '0;
    for (int i = 0; i < CH; i++) begin
      if (!en) begin
        run1[i] = 0;
        run0[i] = 0;
      end else if (c >= m_cmp[i]) begin
        if (run1[i] == 0) ldt[i] = m_dt;
        run1[i]++;
        run0[i] = 0;
      end else begin
        if (run0[i] == 0) ldt[i] = m_dt;
        run0[i]++;
        run1[i] = 0;
      end
      n.h[i] = run1[i] > ldt[i];
      n.l[i] = run0[i] > ldt[i];
    end
    m_ph = en ? (m_ph + 1) % (2 * pe_eff()) : 0;
    if (xfer) begin
      m_pe = sh_pe;
      m_dt = sh_dt;
      m_cmp = sh_cmp;
    end
    if (load) begin
      sh_pe = int'(period);
      sh_dt = int'(deadtime);
      for (int i = 0; i < CH; i++) sh_cmp[i] = int'(cmp[i*CW +: CW]);
    end
    m_pend = load || (m_pend && !xfer);
    n.cnt = CW'(cur_cnt());
    n.dir = cur_dir();
    sbq.push_back(n);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ld(int p, int c0, int c1, int c2, int d);
    period = CW'(p);
    cmp = {CW'(c2), CW'(c1), CW'(c0)};
    deadtime = DW'(d);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_at(int tc, bit td, string tag);
    for (int k = 0; k < 200 && !(cur_cnt() == tc && cur_dir() == td); k++) step();
    chk(tag, 32'(cnt_o), 32'(tc));
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_cnt", 32'(cnt_o), 32'(0));
    chk("rst_dir", 32'(dir_o), 32'(0));
    chk("rst_h", 32'(pwm_h), 32'(0));
    chk("rst_l", 32'(pwm_l), 32'(0));
    chk("rst_ack", 32'(load_ack), 32'(0));
    sys_rst_n = 1'b1;
    ld(10, 5, 5, 5, 0);
    step();
    en = 1'b1;
    repeat (45) step();
    acks = 0;
    ld(10, 5, 3, 7, 3);
    repeat (45) step();
    chk("ack_dt3", 32'(acks), 32'(1));
    wait_at(7, 1'b0, "wait_up7");
    acks = 0;
    ld(20, 8, 8, 8, 3);
    repeat (60) step();
    chk("ack_per20", 32'(acks), 32'(1));
    wait_at(0, 1'b0, "wait_valley");
    acks = 0;
    ld(12, 4, 6, 9, 2);
    ld(14, 2, 7, 13, 2);
    repeat (100) step();
    chk("ack_valley_load", 32'(acks), 32'(1));
    ld(10, 0, 11, 5, 2);
    repeat (50) step();
    ld(1, 0, 2, 3, 1);
    repeat (40) step();
    ld(10, 5, 3, 7, 2);
    repeat (30) step();
    wait_at(6, 1'b1, "wait_down6");
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    repeat (30) step();
    wait_at(5, 1'b0, "wait_up5");
    step();
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt_o), 32'(0));
    chk("arst_dir", 32'(dir_o), 32'(0));
    chk("arst_h", 32'(pwm_h), 32'(0));
    chk("arst_l", 32'(pwm_l), 32'(0));
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    m_reset();
    repeat (3300) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
